// File: rtl/riscv_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access, one transaction in flight.
// Optional starvation guard for fetches is enabled by defining RISCV_ARB_STARVE_GUARD_EN.
module riscv_mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            ma_req,
  input  logic            ma_we,
  input  logic [XLEN-1:0] ma_addr,
  input  logic [XLEN-1:0] ma_wdata,
  output logic            ma_gnt,
  output logic            ma_rvalid,
  output logic [XLEN-1:0] ma_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            owner,
  output logic            proto_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;
  logic   owner_next;
  logic   sel_data;
  logic   starve_hit;

`ifdef RISCV_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign starve_hit = if_req && (starve_cnt == CNT_W'(STARVE_MAX));

  // Counts data wins over a waiting fetch; any fetch selection clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE && (ma_req || if_req)) begin
      if (!sel_data) begin
        starve_cnt <= '0;
      end else if (if_req && starve_cnt != CNT_W'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  assign sel_data = ma_req && !starve_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state <= state_next;
      owner <= owner_next;
      if (mem_rvalid && state != RESP) begin
        proto_err <= 1'b1;
      end
    end
  end

  // Ownership is decided only in IDLE and frozen until the response returns
  always_comb begin
    state_next = state;
    owner_next = owner;
    case (state)
      IDLE: begin
        if (ma_req || if_req) begin
          state_next = REQ;
          owner_next = sel_data;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_gnt    = 1'b0;
    ma_gnt    = 1'b0;
    if_rvalid = 1'b0;
    ma_rvalid = 1'b0;
    if_rdata  = '0;
    ma_rdata  = '0;
    if (state == REQ) begin
      mem_req = 1'b1;
      if (owner) begin
        mem_we    = ma_we;
        mem_addr  = ma_addr;
        mem_wdata = ma_wdata;
        ma_gnt    = mem_gnt;
      end else begin
        mem_addr = if_addr;
        if_gnt   = mem_gnt;
      end
    end
    if (state == RESP && mem_rvalid) begin
      if (owner) begin
        ma_rvalid = 1'b1;
        ma_rdata  = mem_rdata;
      end else begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed self-checking bench for riscv_mem_arbiter; the bench itself plays the memory side.
// Expectations for the fairness test follow RISCV_ARB_STARVE_GUARD_EN when it is defined.
module tb_riscv_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ma_req;
  logic        ma_we;
  logic [31:0] ma_addr;
  logic [31:0] ma_wdata;
  logic        ma_gnt;
  logic        ma_rvalid;
  logic [31:0] ma_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        owner;
  logic        proto_err;

  int check_count = 0;
  int fail_count  = 0;
  int fetch_count;
  logic exp_owner;

  riscv_mem_arbiter #(.XLEN(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
    .ma_gnt(ma_gnt), .ma_rvalid(ma_rvalid), .ma_rdata(ma_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .owner(owner), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one clock, then leave 1ns before inputs change
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b0;
    if_req = 0; if_addr = '0;
    ma_req = 0; ma_we = 0; ma_addr = '0; ma_wdata = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    #12;
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_owner", {31'd0, owner}, 32'd0);
    checkOutput("rst_proto_err", {31'd0, proto_err}, 32'd0);
    checkOutput("rst_gnts", {30'd0, if_gnt, ma_gnt}, 32'd0);
    rst = 1'b1;

    // Test 1: single fetch with immediate grant and next-cycle response
    applyStimulus();
    if_req = 1; if_addr = 32'h100;
    settle();
    checkOutput("t1_idle_mem_req", {31'd0, mem_req}, 32'd0);
    applyStimulus();
    mem_gnt = 1;
    settle();
    checkOutput("t1_mem_req", {31'd0, mem_req}, 32'd1);
    checkOutput("t1_mem_addr", mem_addr, 32'h100);
    checkOutput("t1_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("t1_if_gnt", {31'd0, if_gnt}, 32'd1);
    checkOutput("t1_ma_gnt", {31'd0, ma_gnt}, 32'd0);
    checkOutput("t1_owner", {31'd0, owner}, 32'd0);
    applyStimulus();
    if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    settle();
    checkOutput("t1_resp_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("t1_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    checkOutput("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    checkOutput("t1_ma_rvalid", {31'd0, ma_rvalid}, 32'd0);
    applyStimulus();
    mem_rvalid = 0; mem_rdata = '0;
    settle();
    checkOutput("t1_done_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("t1_done_if_rdata", if_rdata, 32'd0);
    checkOutput("t1_proto_err", {31'd0, proto_err}, 32'd0);

    // Test 2: simultaneous requests, data store wins, fetch follows three cycles later
    if_req = 1; if_addr = 32'h200;
    ma_req = 1; ma_we = 1; ma_addr = 32'h8000; ma_wdata = 32'h55;
    applyStimulus();
    mem_gnt = 1;
    settle();
    checkOutput("t2_owner_data", {31'd0, owner}, 32'd1);
    checkOutput("t2_mem_we", {31'd0, mem_we}, 32'd1);
    checkOutput("t2_mem_addr", mem_addr, 32'h8000);
    checkOutput("t2_mem_wdata", mem_wdata, 32'h55);
    checkOutput("t2_ma_gnt", {31'd0, ma_gnt}, 32'd1);
    checkOutput("t2_if_gnt", {31'd0, if_gnt}, 32'd0);
    applyStimulus();
    ma_req = 0; ma_we = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0;
    settle();
    checkOutput("t2_ma_rvalid", {31'd0, ma_rvalid}, 32'd1);
    checkOutput("t2_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    applyStimulus();
    mem_rvalid = 0;
    settle();
    checkOutput("t2_idle_mem_req", {31'd0, mem_req}, 32'd0);
    applyStimulus();
    mem_gnt = 1;
    settle();
    checkOutput("t2_fetch_mem_req", {31'd0, mem_req}, 32'd1);
    checkOutput("t2_fetch_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("t2_fetch_mem_addr", mem_addr, 32'h200);
    checkOutput("t2_fetch_mem_wdata", mem_wdata, 32'd0);
    checkOutput("t2_fetch_if_gnt", {31'd0, if_gnt}, 32'd1);
    applyStimulus();
    if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1234;
    settle();
    checkOutput("t2_if_rdata", if_rdata, 32'h1234);
    checkOutput("t2_ma_rdata_zero", ma_rdata, 32'd0);
    applyStimulus();
    mem_rvalid = 0; mem_rdata = '0;

    // Test 3: load with grant withheld for five cycles
    ma_req = 1; ma_we = 0; ma_addr = 32'h40;
    applyStimulus();
    for (int i = 0; i < 5; i++) begin
      settle();
      checkOutput($sformatf("t3_wait%0d_mem_req", i), {31'd0, mem_req}, 32'd1);
      checkOutput($sformatf("t3_wait%0d_mem_addr", i), mem_addr, 32'h40);
      checkOutput($sformatf("t3_wait%0d_ma_gnt", i), {31'd0, ma_gnt}, 32'd0);
      checkOutput($sformatf("t3_wait%0d_ma_rvalid", i), {31'd0, ma_rvalid}, 32'd0);
      applyStimulus();
    end
    mem_gnt = 1;
    settle();
    checkOutput("t3_ma_gnt", {31'd0, ma_gnt}, 32'd1);
    applyStimulus();
    ma_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE;
    settle();
    checkOutput("t3_ma_rvalid", {31'd0, ma_rvalid}, 32'd1);
    checkOutput("t3_ma_rdata", ma_rdata, 32'hCAFE);
    applyStimulus();
    mem_rvalid = 0; mem_rdata = '0;

    // Test 4: spurious response in IDLE sets sticky proto_err
    mem_rvalid = 1; mem_rdata = 32'h77;
    settle();
    checkOutput("t4_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    checkOutput("t4_ma_rvalid", {31'd0, ma_rvalid}, 32'd0);
    checkOutput("t4_ma_rdata", ma_rdata, 32'd0);
    applyStimulus();
    mem_rvalid = 0; mem_rdata = '0;
    settle();
    checkOutput("t4_proto_err_set", {31'd0, proto_err}, 32'd1);
    applyStimulus();
    applyStimulus();
    checkOutput("t4_proto_err_sticky", {31'd0, proto_err}, 32'd1);
    rst = 1'b0;
    settle();
    checkOutput("t4_proto_err_cleared", {31'd0, proto_err}, 32'd0);
    rst = 1'b1;

    // Test 5: both requests held; owner pattern per transaction
    applyStimulus();
    if_req = 1; if_addr = 32'h300;
    ma_req = 1; ma_we = 0; ma_addr = 32'h900;
    fetch_count = 0;
    for (int t = 0; t < 20; t++) begin
      applyStimulus();
      mem_gnt = 1;
      settle();
`ifdef RISCV_ARB_STARVE_GUARD_EN
      exp_owner = (t % 5 == 4) ? 1'b0 : 1'b1;
`else
      exp_owner = 1'b1;
`endif
      checkOutput($sformatf("t5_txn%0d_owner", t), {31'd0, owner}, {31'd0, exp_owner});
      if (if_gnt) fetch_count++;
      applyStimulus();
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'(t);
      applyStimulus();
      mem_rvalid = 0;
    end
`ifdef RISCV_ARB_STARVE_GUARD_EN
    checkOutput("t5_fetch_count", 32'(fetch_count), 32'd4);
`else
    checkOutput("t5_fetch_count", 32'(fetch_count), 32'd0);
`endif
    if_req = 0; ma_req = 0;

    // Test 6: reset in RESP drops the in-flight response
    applyStimulus();
    ma_req = 1; ma_we = 0; ma_addr = 32'h500;
    applyStimulus();
    mem_gnt = 1;
    settle();
    checkOutput("t6_owner_before", {31'd0, owner}, 32'd1);
    applyStimulus();
    ma_req = 0; mem_gnt = 0;
    rst = 1'b0;
    settle();
    checkOutput("t6_owner_reset", {31'd0, owner}, 32'd0);
    checkOutput("t6_mem_req_reset", {31'd0, mem_req}, 32'd0);
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    mem_rvalid = 1; mem_rdata = 32'hABCD;
    settle();
    checkOutput("t6_ma_rvalid", {31'd0, ma_rvalid}, 32'd0);
    checkOutput("t6_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    applyStimulus();
    mem_rvalid = 0; mem_rdata = '0;
    settle();
    checkOutput("t6_proto_err", {31'd0, proto_err}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
